// File: rtl/mem_access.sv
// mem_access: memory-access stage of the Pillar core (execute -> mem -> writeback).
// Runs one instruction at a time through an IDLE / ACCESS / RESP state machine and
// drives the data-memory bus with a req/ack handshake for byte/half/word accesses.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an ACCESS left without
// an ack for TIMEOUT cycles is abandoned with fault_o set. When it is undefined,
// ACCESS waits for the ack indefinitely.
module mem_access #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] rs2_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] wd_o,
  output logic        wd_q_readin_o,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t      state_r;
  logic [1:0]  addr_lo_r;   // byte offset of the access, used for lane selection on loads

  logic        is_alu_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        misalign_s;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  // Byte enables for an access of the size encoded in funct3 at byte offset a.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Extract the addressed lane from the read word and sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] lane;
    lane = d >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b100:  return {24'd0, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return d;
    endcase
  endfunction

  // Halfword accesses need an even address and word accesses need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  assign ready_o = (state_r == IDLE) && !reset;

  // Decode the instruction currently offered by execute.
  always_comb begin
    is_alu_s   = 1'b0;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    misalign_s = is_misaligned(ir_i[14:12], alu_i[1:0]);
    case (ir_i[6:0])
      OP_R, OP_I: is_alu_s   = 1'b1;
      OP_LOAD:    is_load_s  = 1'b1;
      OP_STORE:   is_store_s = 1'b1;
      default:    is_alu_s   = 1'b0;
    endcase
  end

  // Stage state machine. All bus and writeback outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      addr_lo_r     <= 2'b00;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= 32'd0;
      dmem_be_o     <= 4'b0000;
      dmem_wdata_o  <= 32'd0;
      wd_o          <= 32'd0;
      wd_q_readin_o <= 1'b0;
      ir_o          <= 32'd0;
      pc_o          <= 32'd0;
      fault_o       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_r    <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          wd_q_readin_o <= 1'b0;
          if (valid_i) begin
            ir_o      <= ir_i;
            pc_o      <= pc_i;
            addr_lo_r <= alu_i[1:0];
            fault_o   <= 1'b0;
            if (is_alu_s) begin
              wd_o          <= alu_i;
              wd_q_readin_o <= 1'b1;
              state_r       <= RESP;
            end else if ((is_load_s || is_store_s) && misalign_s) begin
              // Misaligned: report the fault without touching the bus.
              fault_o <= 1'b1;
              state_r <= RESP;
            end else if (is_load_s || is_store_s) begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= is_store_s;
              dmem_addr_o  <= {alu_i[31:2], 2'b00};
              dmem_be_o    <= byte_en(ir_i[14:12], alu_i[1:0]);
              dmem_wdata_o <= store_data(ir_i[14:12], rs2_i);
`ifdef MEM_TIMEOUT_EN
              wait_cnt_r   <= '0;
`endif
              state_r      <= ACCESS;
            end else begin
              // Unknown opcode: pass ir/pc through with no writeback.
              state_r <= RESP;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            // An ack always completes normally, even on the timeout edge.
            dmem_req_o <= 1'b0;
            state_r    <= RESP;
            if (!dmem_we_o) begin
              wd_o          <= load_ext(ir_o[14:12], addr_lo_r, dmem_rdata_i);
              wd_q_readin_o <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (wait_cnt_r == CNT_LAST) begin
            dmem_req_o <= 1'b0;
            fault_o    <= 1'b1;
            state_r    <= RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
`endif
          end
        end
        RESP: begin
          wd_q_readin_o <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          dmem_req_o    <= 1'b0;
          wd_q_readin_o <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: a table of directed instructions with hand-computed bus and
// writeback values, followed by hand-written sequences for reset, stray acks and the
// long-wait / timeout behaviour (which depends on MEM_TIMEOUT_EN).
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] ir_i, pc_i, alu_i, rs2_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] wd_o;
  logic        wd_q_readin_o;
  logic [31:0] ir_o, pc_o;
  logic        fault_o;

  int errors = 0;
  int checks = 0;

  mem_access #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .ir_i(ir_i), .pc_i(pc_i), .alu_i(alu_i), .rs2_i(rs2_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wd_o(wd_o), .wd_q_readin_o(wd_q_readin_o),
    .ir_o(ir_o), .pc_o(pc_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          delay;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wd;
    logic        exp_stb;
    logic        exp_fault;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one instruction for a single accept edge, then drop valid_i.
  task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2);
    valid_i = 1'b1;
    ir_i    = ir;
    pc_i    = pc;
    alu_i   = alu;
    rs2_i   = rs2;
    step();
    valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] pc;
    pc = 32'h0000_1000 + 32'(idx * 4);
    issue(v.ir, pc, v.alu, v.rs2);
    chk({v.name, ".ready_busy"}, 32'(ready_o), 32'd0);
    if (v.exp_req) begin
      chk({v.name, ".req"},   32'(dmem_req_o), 32'd1);
      chk({v.name, ".we"},    32'(dmem_we_o), 32'(v.exp_we));
      chk({v.name, ".be"},    32'(dmem_be_o), 32'(v.exp_be));
      chk({v.name, ".addr"},  dmem_addr_o, v.exp_addr);
      chk({v.name, ".wdata"}, dmem_wdata_o, v.exp_wdata);
      chk({v.name, ".stb_early"}, 32'(wd_q_readin_o), 32'd0);
      for (int d = 0; d < v.delay; d++) begin
        step();
        chk({v.name, ".req_held"}, 32'(dmem_req_o), 32'd1);
        chk({v.name, ".be_held"},  32'(dmem_be_o), 32'(v.exp_be));
      end
      dmem_ack_i   = 1'b1;
      dmem_rdata_i = v.rdata;
      step();
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
    end
    chk({v.name, ".req_resp"}, 32'(dmem_req_o), 32'd0);
    chk({v.name, ".stb"},      32'(wd_q_readin_o), 32'(v.exp_stb));
    chk({v.name, ".fault"},    32'(fault_o), 32'(v.exp_fault));
    chk({v.name, ".wd"},       wd_o, v.exp_wd);
    chk({v.name, ".ir_o"},     ir_o, v.ir);
    chk({v.name, ".pc_o"},     pc_o, pc);
    step();
    chk({v.name, ".stb_off"},  32'(wd_q_readin_o), 32'd0);
    chk({v.name, ".ready"},    32'(ready_o), 32'd1);
    chk({v.name, ".fault_sticky"}, 32'(fault_o), 32'(v.exp_fault));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        name     ir            alu           rs2           rdata         dly req we  be       addr          wdata         wd            stb  flt
    vecs[0]  = '{"R",     32'h0000_0033, 32'h0000_00AA, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0000_00AA, 1'b1, 1'b0};
    vecs[1]  = '{"LB",    32'h0000_0003, 32'h0000_0103, 32'h0,        32'h80FF_1234, 3, 1'b1, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[2]  = '{"LHU",   32'h0000_5003, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1, 1'b1, 1'b0, 4'b1100, 32'h0000_0100, 32'h0,        32'h0000_80FF, 1'b1, 1'b0};
    vecs[3]  = '{"SH",    32'h0000_1023, 32'h0000_0106, 32'hDEAD_BEEF, 32'h0,       2, 1'b1, 1'b1, 4'b1100, 32'h0000_0104, 32'hBEEF_BEEF, 32'h0000_80FF, 1'b0, 1'b0};
    vecs[4]  = '{"LWmis", 32'h0000_2003, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0000_80FF, 1'b0, 1'b1};
    vecs[5]  = '{"I",     32'h0000_0013, 32'h1234_5678, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h1234_5678, 1'b1, 1'b0};
    vecs[6]  = '{"SB",    32'h0000_0023, 32'h0000_0201, 32'h0000_00A5, 32'h0,       0, 1'b1, 1'b1, 4'b0010, 32'h0000_0200, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{"LHhi",  32'h0000_1003, 32'h0000_0002, 32'h0,        32'h7FFF_8001, 1, 1'b1, 1'b0, 4'b1100, 32'h0,        32'h0,        32'h0000_7FFF, 1'b1, 1'b0};
    vecs[8]  = '{"LHlo",  32'h0000_1003, 32'h0000_0000, 32'h0,        32'h7FFF_8001, 0, 1'b1, 1'b0, 4'b0011, 32'h0,        32'h0,        32'hFFFF_8001, 1'b1, 1'b0};
    vecs[9]  = '{"LBU",   32'h0000_4003, 32'h0000_0001, 32'h0,        32'h0000_80FF, 2, 1'b1, 1'b0, 4'b0010, 32'h0,        32'h0,        32'h0000_0080, 1'b1, 1'b0};
    vecs[10] = '{"LW",    32'h0000_2003, 32'h0000_000C, 32'h0,        32'hCAFE_F00D, 0, 1'b1, 1'b0, 4'b1111, 32'h0000_000C, 32'h0,        32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[11] = '{"SHmis", 32'h0000_1023, 32'h0000_0003, 32'h1111_2222, 32'h0,       0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[12] = '{"OTHER", 32'h0000_007F, 32'h0000_0055, 32'h0,        32'h0,        0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[13] = '{"SW",    32'h0000_2023, 32'h0000_0010, 32'h1122_3344, 32'h0,       1, 1'b1, 1'b1, 4'b1111, 32'h0000_0010, 32'h1122_3344, 32'hCAFE_F00D, 1'b0, 1'b0};

    reset        = 1'b1;
    valid_i      = 1'b0;
    ir_i         = 32'h0;
    pc_i         = 32'h0;
    alu_i        = 32'h0;
    rs2_i        = 32'h0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;

    // Reset state: everything zero and not ready while reset is high.
    step();
    step();
    chk("rst.ready", 32'(ready_o), 32'd0);
    chk("rst.req",   32'(dmem_req_o), 32'd0);
    chk("rst.we",    32'(dmem_we_o), 32'd0);
    chk("rst.be",    32'(dmem_be_o), 32'd0);
    chk("rst.addr",  dmem_addr_o, 32'd0);
    chk("rst.wdata", dmem_wdata_o, 32'd0);
    chk("rst.wd",    wd_o, 32'd0);
    chk("rst.stb",   32'(wd_q_readin_o), 32'd0);
    chk("rst.ir",    ir_o, 32'd0);
    chk("rst.pc",    pc_o, 32'd0);
    chk("rst.fault", 32'(fault_o), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst.ready_after", 32'(ready_o), 32'd1);

    // A stray ack in IDLE has no effect.
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    step();
    dmem_ack_i   = 1'b0;
    chk("stray.stb", 32'(wd_q_readin_o), 32'd0);
    chk("stray.req", 32'(dmem_req_o), 32'd0);
    chk("stray.wd",  wd_o, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset in the middle of ACCESS abandons the access; a late ack is ignored.
    issue(32'h0000_2003, 32'h0000_2000, 32'h0000_0020, 32'h0);
    chk("midrst.req_before", 32'(dmem_req_o), 32'd1);
    reset = 1'b1;
    step();
    chk("midrst.req_after", 32'(dmem_req_o), 32'd0);
    chk("midrst.ready_in_reset", 32'(ready_o), 32'd0);
    reset        = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h1357_9BDF;
    step();
    dmem_ack_i   = 1'b0;
    chk("midrst.late_ack_stb", 32'(wd_q_readin_o), 32'd0);
    chk("midrst.late_ack_wd",  wd_o, 32'd0);
    chk("midrst.ready",        32'(ready_o), 32'd1);
    chk("midrst.req_idle",     32'(dmem_req_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: request held for exactly 15 ACCESS cycles, then a fault with no strobe.
    issue(32'h0000_2003, 32'h0000_3000, 32'h0000_0040, 32'h0);
    for (int c = 0; c < 14; c++) begin
      chk("tmo.req_held", 32'(dmem_req_o), 32'd1);
      step();
    end
    chk("tmo.req_last", 32'(dmem_req_o), 32'd1);
    step();
    chk("tmo.req_drop", 32'(dmem_req_o), 32'd0);
    chk("tmo.fault",    32'(fault_o), 32'd1);
    chk("tmo.stb",      32'(wd_q_readin_o), 32'd0);
    step();
    chk("tmo.ready",    32'(ready_o), 32'd1);
    // Ack on the timeout edge wins.
    issue(32'h0000_2003, 32'h0000_3004, 32'h0000_0044, 32'h0);
    for (int c = 0; c < 14; c++) begin
      step();
    end
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0000_0055;
    step();
    dmem_ack_i   = 1'b0;
    chk("tmo_ack.stb",   32'(wd_q_readin_o), 32'd1);
    chk("tmo_ack.fault", 32'(fault_o), 32'd0);
    chk("tmo_ack.wd",    wd_o, 32'h0000_0055);
    step();
`else
    // Without the timeout the access waits as long as needed.
    issue(32'h0000_2003, 32'h0000_3000, 32'h0000_0040, 32'h0);
    for (int c = 0; c < 20; c++) begin
      step();
    end
    chk("wait.req_held", 32'(dmem_req_o), 32'd1);
    chk("wait.fault",    32'(fault_o), 32'd0);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0000_0055;
    step();
    dmem_ack_i   = 1'b0;
    chk("wait.stb", 32'(wd_q_readin_o), 32'd1);
    chk("wait.wd",  wd_o, 32'h0000_0055);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
